// File: rtl/red_sched.sv
// red_sched: round-robin scheduler that shares one sequential GF(2^m)
// reduction unit between NUM_REQ requesters.
//
// A job is accepted from one requester at a time and its operands are
// latched. The reduction unit is then enabled for grade+LAT_EXTRA cycles,
// its result is captured, and the result is returned with the requester
// index on a valid/ready response channel.
//
// Optional feature: define RED_SCHED_GRADE_CHECK_EN to reject jobs whose
// grade is below 2 or above DATA_WIDTH. A rejected job still completes its
// handshake but skips the datapath and is answered with resp_err=1.
module red_sched #(
   parameter  int DATA_WIDTH = 4,
   parameter  int NUM_REQ    = 4,
   parameter  int LAT_EXTRA  = 4,
   localparam int GW         = $clog2(DATA_WIDTH) + 1,
   localparam int IW         = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   // job request channel, one lane per requester
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*GW-1:0]           req_grade,
   input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_poly,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
   // response channel
   output logic                            resp_valid,
   input  logic                            resp_ready,
   output logic [IW-1:0]                   resp_id,
   output logic [DATA_WIDTH-1:0]           resp_data,
   output logic                            resp_err,
   // shared reduction unit
   output logic                            red_op_enable,
   output logic [GW-1:0]                   red_polyn_grade,
   output logic [DATA_WIDTH:0]             red_polyn_red_in,
   output logic [2*DATA_WIDTH-1:0]         red_reduc_in,
   input  logic [DATA_WIDTH-1:0]           red_out
);

   // run_cnt is wide enough for grade+LAT_EXTRA so it never wraps in a job
   localparam int RCW = GW + $clog2(LAT_EXTRA + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;

   // arbitration
   logic [IW-1:0]           rr_ptr;
   logic [IW-1:0]           grant_idx;
   logic                    grant_found;
   logic                    handshake;

   // operands of the selected requester
   logic [GW-1:0]           sel_grade;
   logic [DATA_WIDTH:0]     sel_poly;
   logic [2*DATA_WIDTH-1:0] sel_data;

   // latched job
   logic [GW-1:0]           op_grade;
   logic [DATA_WIDTH:0]     op_poly;
   logic [2*DATA_WIDTH-1:0] op_data;
   logic [IW-1:0]           op_id;

   // run length control
   logic [RCW-1:0]          run_cnt;
   logic [RCW-1:0]          run_last;
   logic                    run_done;

   // response holding register
   logic [DATA_WIDTH-1:0]   resp_data_q;

   // Index of the requester 'offset' places above 'base', wrapping at NUM_REQ.
   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base,
                                              input int            offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return IW'(sum);
   endfunction

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   // NOTE: every signal assigned in a combinational block gets a default at
   // the top so no path leaves it unassigned; a missing default infers a latch.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[rr_index(rr_ptr, k)]) begin
            grant_found = 1'b1;
            grant_idx   = rr_index(rr_ptr, k);
         end
      end
   end

   // a job is taken only while idle; ready is raised for the granted lane
   assign handshake = (state_q == S_IDLE) && grant_found;

   assign sel_grade = req_grade[grant_idx*GW +: GW];
   assign sel_poly  = req_poly[grant_idx*(DATA_WIDTH+1) +: (DATA_WIDTH+1)];
   assign sel_data  = req_data[grant_idx*2*DATA_WIDTH +: 2*DATA_WIDTH];

   // last RUN cycle: run_cnt counts 0 .. grade+LAT_EXTRA-1
   assign run_last = RCW'(op_grade) + RCW'(LAT_EXTRA - 1);
   assign run_done = (state_q == S_RUN) && (run_cnt == run_last);

`ifdef RED_SCHED_GRADE_CHECK_EN
   logic grade_bad;

   // grades outside 2..DATA_WIDTH cannot be reduced meaningfully
   assign grade_bad = (sel_grade < GW'(2)) || (sel_grade > GW'(DATA_WIDTH));
`endif

   // State register.
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples values from before the edge, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> RUN (or RESP on a rejected job) -> RESP -> IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (handshake) begin
`ifdef RED_SCHED_GRADE_CHECK_EN
               state_d = grade_bad ? S_RESP : S_RUN;
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (run_done) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state: ready in IDLE, datapath drive in RUN,
   // response valid in RESP. The datapath sees zeros outside RUN.
   always_comb begin
      req_ready        = '0;
      resp_valid       = 1'b0;
      red_op_enable    = 1'b0;
      red_polyn_grade  = '0;
      red_polyn_red_in = '0;
      red_reduc_in     = '0;
      unique case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
            end
         end
         S_RUN: begin
            red_op_enable    = 1'b1;
            red_polyn_grade  = op_grade;
            red_polyn_red_in = op_poly;
            red_reduc_in     = op_data;
         end
         S_RESP: begin
            resp_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Round-robin pointer: moves past the winner only on an accepted job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Run counter: cleared on acceptance, counts every RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else if (handshake) begin
         run_cnt <= '0;
      end else if (state_q == S_RUN) begin
         run_cnt <= run_cnt + 1'b1;
      end
   end

   // Operand registers: hold the accepted job stable for the whole run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_grade <= '0;
         op_poly  <= '0;
         op_data  <= '0;
         op_id    <= '0;
      end else if (handshake) begin
         op_grade <= sel_grade;
         op_poly  <= sel_poly;
         op_data  <= sel_data;
         op_id    <= grant_idx;
      end
   end

`ifdef RED_SCHED_GRADE_CHECK_EN
   logic resp_err_q;

   // Response registers: result captured on the last RUN cycle; a rejected
   // job answers with zero data and the error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else if (handshake && grade_bad) begin
         resp_data_q <= '0;
         resp_err_q  <= 1'b1;
      end else if (run_done) begin
         resp_data_q <= red_out;
         resp_err_q  <= 1'b0;
      end
   end

   assign resp_err = resp_err_q;
`else
   // Response register: result captured on the last RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_data_q <= '0;
      end else if (run_done) begin
         resp_data_q <= red_out;
      end
   end

   assign resp_err = 1'b0;
`endif

   assign resp_id   = op_id;
   assign resp_data = resp_data_q;

endmodule

// File: doc/red_sched.md
# red_sched

Round-robin scheduler that shares one sequential GF(2^m) reduction unit between `NUM_REQ` requesters. It accepts jobs over per-requester valid/ready handshakes and latches each job's operands. It drives the reduction unit's `op_enable` / `polyn_grade` / `polyn_red_in` / `reduc_in` for a fixed, grade-dependent number of cycles, then captures the unit's `out` and returns it with the requester ID over a valid/ready response channel. It sits between the multiplier front-ends and the single shared reduction datapath.

## Interface
- `DATA_WIDTH`, 4: field width m; must match the reduction unit.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `LAT_EXTRA`, 4: fixed pipeline cycles added to grade to form the datapath run length.
- `GW` (localparam) = $clog2(DATA_WIDTH)+1; `IW` (localparam) = $clog2(NUM_REQ).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  job offered by requester i.
- `req_ready`  out  NUM_REQ  job accepted from requester i (one-hot or zero).
- `req_grade`  in  NUM_REQ*GW  packed polynomial grades, slice i = requester i.
- `req_poly`  in  NUM_REQ*(DATA_WIDTH+1)  packed primitive polynomials.
- `req_data`  in  NUM_REQ*2*DATA_WIDTH  packed polynomials to reduce.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes result.
- `resp_id`  out  IW  requester index of result.
- `resp_data`  out  DATA_WIDTH  reduced polynomial.
- `resp_err`  out  1  job rejected (see Configuration).
- `red_op_enable`  out  1  to reduction unit `op_enable`.
- `red_polyn_grade`  out  GW  to `polyn_grade`.
- `red_polyn_red_in`  out  DATA_WIDTH+1  to `polyn_red_in`.
- `red_reduc_in`  out  2*DATA_WIDTH  to `reduc_in`.
- `red_out`  in  DATA_WIDTH  from reduction unit `out`.

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - `red_op_enable`=0, which clears the datapath.
  - Round-robin grant among `req_valid`, searching upward from `rr_ptr`. `req_ready[g]` is asserted combinationally in the same cycle; ready may depend on valid.
  - On handshake: latch grade/poly/data/id into operand registers, clear `run_cnt`, set `rr_ptr`=g+1 mod NUM_REQ, then go to RUN. If the job is rejected, go to RESP with `resp_err`=1 instead.
- RUN:
  - `red_op_enable`=1; `red_*` operands are driven from the operand registers and held stable.
  - `run_cnt` increments each cycle.
  - When `run_cnt` == grade+LAT_EXTRA−1: capture `red_out` into `resp_data`, set `resp_err`=0, go to RESP.
- RESP:
  - `resp_valid`=1; `resp_id`, `resp_data` and `resp_err` are held.
  - On `resp_valid && resp_ready`: go to IDLE.
- `req_ready` is all-zero in RUN and RESP.
- `run_cnt` width is GW+$clog2(LAT_EXTRA+1) bits; it never wraps within a job.
- `rr_ptr` only advances on an accepted handshake. It wraps from NUM_REQ−1 to 0.

## Timing
- Reset (async assert, sync-released use) values:
  - state=IDLE, `rr_ptr`=0, `run_cnt`=0.
  - All `req_ready`=0 (no valids are seen during reset), `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0.
  - `red_op_enable`=0; all `red_*` operand outputs = 0.
- Reset mid-RUN or mid-RESP: the job is dropped, no response is produced, and `red_op_enable` falls immediately.
- `red_op_enable` is high for exactly grade+LAT_EXTRA consecutive cycles per job.
- `resp_valid` rises grade+LAT_EXTRA+1 cycles after the handshake edge.
- Minimum spacing between handshakes is grade+LAT_EXTRA+2 cycles (at least one IDLE cycle with `red_op_enable`=0).
- `resp_ready` held high in the same cycle `resp_valid` rises: the result is taken on that edge and IDLE follows.
- A requester dropping `req_valid` without a handshake is legal; its operands are never sampled.

## Configuration
- `RED_SCHED_GRADE_CHECK_EN`
  - Defined: in IDLE a grade <2 or >DATA_WIDTH is still accepted (handshake completes) but skips RUN. RESP follows on the next cycle with `resp_err`=1 and `resp_data`=0; `red_op_enable` stays 0.
  - Undefined: no check; every job runs, and `resp_err` is tied to 0.

## Test plan
- DATA_WIDTH=4, req0 grade=4, poly=5'b10011, data=8'h10 (x^4) → one `red_op_enable` window of 8 cycles; `resp_valid` 9 cycles after the handshake; `resp_id`=0, `resp_data`=4'h3.
- All four requesters valid continuously with data=8'h00 → grants in order 0,1,2,3,0; every `resp_data`=0; `red_op_enable` low for at least one cycle between windows.
- `resp_ready` held low for 5 cycles after `resp_valid` → `resp_*` stable throughout; no new `req_ready` until the response is taken.
- Only req2 valid, `rr_ptr`=3 → grant 2 (wrap search); `rr_ptr` becomes 3.
- `rst_n` pulsed low in the 3rd RUN cycle → `red_op_enable`=0 and `resp_valid`=0 immediately; after release the next job from `rr_ptr`=0 completes normally.
- With the macro defined, grade=1 → handshake, `resp_valid` next cycle, `resp_err`=1, `resp_data`=0, no `red_op_enable` pulse. Without the macro, the same job runs 5 cycles and `resp_err`=0.
